// File: rtl/sample_buffer_ctrl_pkg.sv
// Shared types and constants for the double-buffered sample capture controller.
// Used by sample_buffer_ctrl and trigger_detect.
package sample_buffer_ctrl_pkg;

    localparam int unsigned HALF_LOG2_DEFAULT = 8;
    localparam int unsigned SAMPLE_W          = 16;
    localparam int unsigned STORE_W           = 8;

    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Signed 16-bit sample to unsigned 8-bit offset binary (top byte, MSB flipped)
    function automatic logic [STORE_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] sample);
        return {~sample[SAMPLE_W-1], sample[SAMPLE_W-2 -: STORE_W-1]};
    endfunction

endpackage

// File: rtl/sample_buffer_ctrl_trigger_detect.sv
// Capture trigger for the sample buffer: tracks the previous sample sign and
// flags the sample that starts a capture. Optional macro: ZERO_CROSS_TRIGGER_EN.
module trigger_detect (
    input  logic clk,
    input  logic reset,
    input  logic new_sample_ready,
    input  logic sample_msb,
    input  logic armed,
    output logic trigger_c
);

`ifdef ZERO_CROSS_TRIGGER_EN
    localparam bit ZERO_CROSS_EN = 1'b1;
`else
    localparam bit ZERO_CROSS_EN = 1'b0;
`endif

    logic prev_msb;

    // Sign of the last strobed sample, tracked in every state
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_msb <= 1'b0;
        end else if (new_sample_ready) begin
            prev_msb <= sample_msb;
        end
    end

    // Rising zero crossing when enabled, otherwise any strobe while armed
    always_comb begin
        trigger_c = armed & new_sample_ready
                  & (!ZERO_CROSS_EN | (prev_msb & ~sample_msb));
    end

endmodule

// File: rtl/sample_buffer_ctrl.sv
// Ping-pong sample RAM fill controller: fills the half the display is not reading,
// then waits for a display-idle window to swap. Optional macro: ZERO_CROSS_TRIGGER_EN.
module sample_buffer_ctrl
    import sample_buffer_ctrl_pkg::*;
#(
    parameter int unsigned HALF_LOG2 = HALF_LOG2_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_sample_ready,
    input  logic [SAMPLE_W-1:0]  new_sample_in,
    input  logic                 wave_display_idle,
    output logic [HALF_LOG2:0]   write_address,
    output logic                 write_enable,
    output logic [STORE_W-1:0]   write_sample,
    output logic                 read_index,
    output logic                 capturing
);

    localparam int unsigned ADDR_W = HALF_LOG2 + 1;
    localparam logic [HALF_LOG2-1:0] COUNT_LAST = '1;

    state_t                state, state_d;
    logic [HALF_LOG2-1:0]  count, count_d;
    logic                  read_index_d;
    logic                  write_enable_d;
    logic [ADDR_W-1:0]     write_address_d;
    logic [STORE_W-1:0]    write_sample_d;
    logic                  capturing_d;
    logic                  armed_c;
    logic                  trigger_c;
    logic                  accept_c;

    assign armed_c = (state == ARMED);

    trigger_detect u_trigger_detect (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .sample_msb       (new_sample_in[SAMPLE_W-1]),
        .armed            (armed_c),
        .trigger_c        (trigger_c)
    );

    // State, counter and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ARMED;
            count         <= '0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
            capturing     <= 1'b0;
        end else begin
            state         <= state_d;
            count         <= count_d;
            read_index    <= read_index_d;
            write_enable  <= write_enable_d;
            write_address <= write_address_d;
            write_sample  <= write_sample_d;
            capturing     <= capturing_d;
        end
    end

    // Next state and next register values
    always_comb begin
        state_d         = state;
        count_d         = count;
        read_index_d    = read_index;
        write_enable_d  = 1'b0;
        write_address_d = write_address;
        write_sample_d  = write_sample;
        accept_c        = 1'b0;

        case (state)
            ARMED: begin
                // count is always zero here, so the trigger sample lands at slot 0
                if (trigger_c) begin
                    accept_c = 1'b1;
                    state_d  = ACTIVE;
                    count_d  = count + HALF_LOG2'(1);
                end
            end
            ACTIVE: begin
                if (new_sample_ready) begin
                    accept_c = 1'b1;
                    count_d  = count + HALF_LOG2'(1);
                    if (count == COUNT_LAST) begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wave_display_idle) begin
                    read_index_d = ~read_index;
                    state_d      = ARMED;
                end
            end
            default: begin
                state_d = ARMED;
                count_d = '0;
            end
        endcase

        if (accept_c) begin
            write_enable_d  = 1'b1;
            write_address_d = {~read_index, count};
            write_sample_d  = to_offset_binary(new_sample_in);
        end

        capturing_d = (state_d == ACTIVE);
    end

endmodule

// File: doc/sample_buffer_ctrl.md
SAMPLE_BUFFER_CTRL -- requirements
Module: sample_buffer_ctrl

Interface
REQ-001 Parameter: HALF_LOG2, default 8, log2 of samples per RAM half; write_address width is HALF_LOG2+1.
REQ-002 Port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: new_sample_ready  input  1  one-cycle strobe; new_sample_in valid this cycle.
REQ-005 Port: new_sample_in  input  16  signed two's-complement audio sample.
REQ-006 Port: wave_display_idle  input  1  high while the display is outside the waveform drawing region; safe to swap halves.
REQ-007 Port: write_address  output  HALF_LOG2+1  sample RAM write address; MSB is the half being filled.
REQ-008 Port: write_enable  output  1  one-cycle sample RAM write strobe.
REQ-009 Port: write_sample  output  8  unsigned sample to store.
REQ-010 Port: read_index  output  1  half of the sample RAM the display reads.
REQ-011 Port: capturing  output  1  high in state ACTIVE.

Function
REQ-012 The block SHALL implement states ARMED, ACTIVE and WAIT.
REQ-013 The fill half SHALL always be ~read_index; write_address SHALL be {~read_index, count}, where count is a HALF_LOG2-bit register.
REQ-014 write_sample SHALL be new_sample_in[15:8] with bit 7 inverted (signed-to-offset-binary): 16'h8000 -> 8'h00, 16'h0000 -> 8'h80, 16'h7FFF -> 8'hFF.
REQ-015 A sample is "accepted" when new_sample_ready is high in ACTIVE, or when it causes ARMED->ACTIVE.
REQ-016 For each accepted sample, write_enable, write_address and write_sample SHALL be registered and valid exactly one cycle after the strobe; write_enable SHALL be high for that one cycle only.
REQ-017 prev_msb SHALL capture new_sample_in[15] on every new_sample_ready in every state.
REQ-018 ARMED->ACTIVE SHALL occur on new_sample_ready when the trigger condition holds (see Configuration); the triggering sample SHALL be written at count 0.
REQ-019 In ACTIVE each accepted sample SHALL be written at count, then count increments; the write at count = 2^HALF_LOG2-1 SHALL move the state to WAIT and wrap count to 0.
REQ-020 In WAIT, new_sample_ready SHALL be ignored (no write).
REQ-021 In WAIT with wave_display_idle high, read_index SHALL toggle and the state SHALL go to ARMED on the same edge.
REQ-022 read_index SHALL change only on the WAIT->ARMED transition.
REQ-023 wave_display_idle SHALL be ignored in ARMED and ACTIVE.
REQ-024 new_sample_ready high in the same cycle as the final ACTIVE write completes SHALL be treated as a single accepted sample; no sample is written twice or skipped in ACTIVE.

Reset
REQ-025 On reset: state ARMED, count 0, prev_msb 0, read_index 0, write_enable 0, write_address 0, write_sample 0, capturing 0.
REQ-026 Reset asserted mid-ACTIVE or mid-WAIT SHALL abandon the partial fill with no write in the following cycle.

Configuration
REQ-027 Macro ZERO_CROSS_TRIGGER_EN defined: trigger condition = prev_msb==1 and new_sample_in[15]==0 (rising zero crossing).
REQ-028 Macro ZERO_CROSS_TRIGGER_EN undefined: trigger condition = any new_sample_ready in ARMED.

Structure
REQ-029 A shared package SHALL hold the state encoding constants (ARMED, ACTIVE, WAIT) and the default HALF_LOG2.
REQ-030 One sub-module, trigger_detect, SHALL hold prev_msb and produce the trigger pulse; the FSM, counter and output registers stay at top level.

Verification
REQ-031 Reset, then 3 cycles idle -> all outputs 0, capturing 0.
REQ-032 Macro defined, samples 16'hF000, 16'h0100 -> one write, address 9'h100, data 8'h81, one cycle after the second strobe; capturing 1.
REQ-033 Macro defined, 256 strobes after trigger, first trigger sample 16'h0100 -> 256 writes, addresses 9'h100..9'h1FF, state WAIT; further strobes produce no writes.
REQ-034 In WAIT, wave_display_idle=1 -> read_index 0->1 next edge; next fill targets addresses 9'h000..9'h0FF.
REQ-035 Macro undefined, strobe with 16'h8000 in ARMED -> write at address 9'h100, data 8'h00.
REQ-036 Reset asserted after 100 ACTIVE writes -> no further writes, read_index 0, next fill restarts at count 0.
